// File: rtl/add_result_if.sv
// Handshake bundle between the carry-select adder, the result stage and its consumer.
// The master side drives the adder results and out_ready; the slave side is the result stage.
interface add_result_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_ovf;
  logic             in_a_msb;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             out_ovf;
  logic             out_sat;

  modport master (
    output in_valid, in_sum, in_cout, in_ovf, in_a_msb, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_ovf, out_sat
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_ovf, in_a_msb, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_ovf, out_sat
  );
endinterface

// File: rtl/add_result_stage.sv
// Registered output stage for the 32-bit adder: optional saturation at capture, 2-entry skid
// buffer with valid/ready on both sides, and a saturating overflow event counter.
module add_result_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  add_result_if.slave          bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             cout;
    logic             ovf;
    logic             sat;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e               state_q, state_d;
  entry_t               head_q, head_d;
  entry_t               skid_q, skid_d;
  entry_t               cap;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept, emit;

  assign accept = bus.in_valid && in_ready_q;
  assign emit   = out_valid_q && bus.out_ready;

  // Clamp direction follows operand A's sign; the raw flags are always kept.
  always_comb begin
    cap.data = bus.in_sum;
    cap.cout = bus.in_cout;
    cap.ovf  = bus.in_ovf;
    cap.sat  = 1'b0;
    if (bus.in_ovf && bus.sat_en) begin
      cap.sat  = 1'b1;
      cap.data = bus.in_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        head_d  = cap;
        state_d = ONE;
      end
      ONE: begin
        if (accept && emit) begin
          head_d = cap;
        end else if (accept) begin
          skid_d  = cap;
          state_d = TWO;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: if (emit) begin
        head_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Ready/valid are registered from the next state so out_ready never reaches in_ready combinationally.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = (accept && bus.in_ovf) ? CNT_WIDTH'(1) : '0;
    else if (accept && bus.in_ovf && cnt_q != '1)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_q.data;
  assign bus.out_cout  = head_q.cout;
  assign bus.out_ovf   = head_q.ovf;
  assign bus.out_sat   = head_q.sat;
  assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Bench for add_result_stage: a FIFO-queue model checked every cycle plus directed literal checks.
module tb_add_result_stage;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] data;
    logic         cout;
    logic         ovf;
    logic         sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clr;
  logic [CW-1:0] ovf_count;

  add_result_if #(.WIDTH(W)) bus ();

  add_result_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  exp_t mq[$];
  int mcnt = 0;
  logic [W-1:0] log_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a 2-deep FIFO of what each accepted input must look like on the output.
  always @(posedge clk) begin
    bit acc, em;
    exp_t e;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      acc = bus.in_valid && (mq.size() < 2);
      em  = (mq.size() > 0) && bus.out_ready;
      if (em) void'(mq.pop_front());
      if (acc) begin
        e.cout = bus.in_cout;
        e.ovf  = bus.in_ovf;
        if (bus.in_ovf && bus.sat_en) begin
          e.sat  = 1'b1;
          e.data = bus.in_a_msb ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          e.sat  = 1'b0;
          e.data = bus.in_sum;
        end
        mq.push_back(e);
      end
      if (cnt_clr) mcnt = (acc && bus.in_ovf) ? 1 : 0;
      else if (acc && bus.in_ovf && mcnt < CMAX) mcnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("m_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      chk("m_in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
      chk("m_ovf_count", 64'(ovf_count), 64'(mcnt));
      if (mq.size() > 0) begin
        chk("m_out_data", 64'(bus.out_data), 64'(mq[0].data));
        chk("m_out_cout", 64'(bus.out_cout), 64'(mq[0].cout));
        chk("m_out_ovf", 64'(bus.out_ovf), 64'(mq[0].ovf));
        chk("m_out_sat", 64'(bus.out_sat), 64'(mq[0].sat));
      end
      if (bus.out_valid && bus.out_ready) log_q.push_back(bus.out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    cnt_clr      = 1'b0;
  endtask

  task automatic drive(input logic [W-1:0] s, input logic c, input logic o,
                       input logic a, input logic se);
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_cout  = c;
    bus.in_ovf   = o;
    bus.in_a_msb = a;
    bus.sat_en   = se;
  endtask

  // Present one input and hold it until the stage takes it; returns just after the accept edge.
  task automatic send(input logic [W-1:0] s, input logic c, input logic o,
                      input logic a, input logic se);
    int n = 0;
    drive(s, c, o, a, se);
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 20) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    step();
  endtask

  logic [W-1:0] v;

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sum = '0;
    bus.in_cout = 1'b0;
    bus.in_ovf = 1'b0;
    bus.in_a_msb = 1'b0;
    bus.sat_en = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    chk("rst_ovf_count", 64'(ovf_count), 64'd0);
    chk_on = 1'b1;
    step();

    // maxInt+1 clamps to maxInt
    drive(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'h7FFF_FFFF);
    chk("t1_sat", 64'(bus.out_sat), 64'd1);
    chk("t1_ovf", 64'(bus.out_ovf), 64'd1);
    chk("t1_count", 64'(ovf_count), 64'd1);
    step();

    // minInt-1 clamps to minInt; same input unsaturated passes the wrapped sum
    drive(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("t2_data", 64'(bus.out_data), 64'h8000_0000);
    chk("t2_sat", 64'(bus.out_sat), 64'd1);
    chk("t2_cout", 64'(bus.out_cout), 64'd1);
    step();
    drive(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("t2b_data", 64'(bus.out_data), 64'h7FFF_FFFF);
    chk("t2b_sat", 64'(bus.out_sat), 64'd0);
    chk("t2b_ovf", 64'(bus.out_ovf), 64'd1);
    chk("t2b_count", 64'(ovf_count), 64'd3);
    step();
    step();

    // Backpressure: two entries fill the buffer, the third waits
    log_q.delete();
    bus.out_ready = 1'b0;
    send(32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'hFFFF_FFF6, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
    chk("t3_hold_data", 64'(bus.out_data), 64'd5);
    step();
    step();
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFF6, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    step();
    step();
    step();
    chk("t3_log_size", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      chk("t3_log0", 64'(log_q[0]), 64'd5);
      chk("t3_log1", 64'(log_q[1]), 64'd10);
      chk("t3_log2", 64'(log_q[2]), 64'hFFFF_FFF6);
    end

    // Streaming: one result per cycle, latency one
    drive(32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 7) drive(32'(3 * (k + 1) + 1), 1'(k + 1), 1'b0, 1'b0, 1'b0);
      else idle();
      @(negedge clk);
      chk("t4_valid", 64'(bus.out_valid), 64'd1);
      chk("t4_ready", 64'(bus.in_ready), 64'd1);
      chk("t4_data", 64'(bus.out_data), 64'(3 * k + 1));
    end
    step();

    // Counter saturation and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", 64'(ovf_count), 64'd0);
    step();
    drive(32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("t5_count15", 64'(ovf_count), 64'd15);
    step();
    drive(32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("t5_count_sat", 64'(ovf_count), 64'd15);
    step();
    drive(32'h0000_0042, 1'b0, 1'b1, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    step();
    idle();
    @(negedge clk);
    chk("t5_clr_push", 64'(ovf_count), 64'd1);
    step();
    step();

    // Reset while full drops both entries
    bus.out_ready = 1'b0;
    send(32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("t6_full", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_count", 64'(ovf_count), 64'd0);
    chk("t6_data", 64'(bus.out_data), 64'd0);
    step();
    log_q.delete();
    bus.out_ready = 1'b1;
    v = 32'hABCD_0123;
    send(v, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    step();
    step();
    step();
    chk("t6_log_size", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("t6_log0", 64'(log_q[0]), 64'(v));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
